logic_axi4_stream_mux_arbiter: RTL and testbench

Packet-aware round-robin arbiter that sequences a shared AXI4-Stream mux datapath between INPUTS requesters.
- Issues a registered one-hot grant plus encoded select to the mux.
- Holds the grant for a whole packet (until TLAST) or for a bounded burst.
- Re-arbitrates on release with no idle bubble.
- Sits beside the mux stage/unit datapath and drives its select.

---
 rtl/logic_axi4_stream_mux_arbiter.sv | 117 +++++++++++
 tb/tb_logic_axi4_stream_mux_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/logic_axi4_stream_mux_arbiter.sv
// Packet-aware round-robin arbiter driving the select of a shared AXI4-Stream mux.
// Grants are held until TLAST and/or a burst limit, then re-arbitrated with no idle cycle.
module logic_axi4_stream_mux_arbiter #(
  parameter int INPUTS      = 2,
  parameter int USE_TLAST   = 1,
  parameter int MAX_BURST   = 0,
  parameter int INDEX_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic [INPUTS-1:0]      request,
  input  logic [INPUTS-1:0]      tlast,
  input  logic                   tx_tready,
  output logic [INPUTS-1:0]      grant,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   grant_valid,
  output logic [15:0]            beat_count
);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                 state_q, state_d;
  logic [INPUTS-1:0]      grant_q, grant_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [15:0]            cnt_q, cnt_d;

  logic [2*INPUTS-1:0]    rot;
  int                     off;
  logic                   win_found;
  logic [INDEX_WIDTH-1:0] win_idx;
  logic                   transfer;
  logic                   release_beat;

  // Doubled request vector shifted so bit 0 is the input just after the pointer.
  always_comb begin
    rot       = {request, request} >> (int'(ptr_q) + 1);
    off       = 0;
    win_found = 1'b0;
    for (int k = INPUTS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off       = k;
        win_found = 1'b1;
      end
    end
    win_idx = INDEX_WIDTH'((int'(ptr_q) + 1 + off) % INPUTS);
  end

  assign transfer = (state_q == GRANTED) & request[idx_q] & tx_tready;

  always_comb begin
    release_beat = 1'b0;
    if (USE_TLAST != 0 && tlast[idx_q])                      release_beat = 1'b1;
    if (MAX_BURST > 0 && cnt_q == 16'(MAX_BURST - 1))        release_beat = 1'b1;
    if (USE_TLAST == 0 && MAX_BURST == 0)                    release_beat = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANTED;
          grant_d = INPUTS'(1) << win_idx;
          idx_d   = win_idx;
          ptr_d   = win_idx;
          cnt_d   = '0;
        end
      end
      GRANTED: begin
        if (transfer) begin
          if (release_beat) begin
            // Pointer already sits on the owner, so the owner ranks last here.
            if (win_found) begin
              grant_d = INPUTS'(1) << win_idx;
              idx_d   = win_idx;
              ptr_d   = win_idx;
            end else begin
              state_d = IDLE;
              grant_d = '0;
            end
            cnt_d = '0;
          end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= INDEX_WIDTH'(INPUTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_index = idx_q;
  assign grant_valid = (state_q == GRANTED);
  assign beat_count  = cnt_q;

endmodule

// File: tb/tb_logic_axi4_stream_mux_arbiter.sv
// Scoreboard bench: three arbiter configurations driven by directed per-cycle vectors,
// expected post-edge outputs queued by the stimulus and checked by an independent monitor.
module tb_logic_axi4_stream_mux_arbiter;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic areset_n;

  // A: INPUTS=2, TLAST release, unlimited burst
  logic [1:0]  a_req, a_last, a_grant;
  logic        a_rdy, a_gv;
  logic [0:0]  a_idx;
  logic [15:0] a_cnt;
  // B: INPUTS=3, TLAST ignored, 4-beat bursts
  logic [2:0]  b_req, b_last, b_grant;
  logic        b_rdy, b_gv;
  logic [1:0]  b_idx;
  logic [15:0] b_cnt;
  // C: INPUTS=2, TLAST release plus 2-beat burst limit
  logic [1:0]  c_req, c_last, c_grant;
  logic        c_rdy, c_gv;
  logic [0:0]  c_idx;
  logic [15:0] c_cnt;

  logic_axi4_stream_mux_arbiter #(.INPUTS(2), .USE_TLAST(1), .MAX_BURST(0)) u_a (
    .aclk(aclk), .areset_n(areset_n), .request(a_req), .tlast(a_last), .tx_tready(a_rdy),
    .grant(a_grant), .grant_index(a_idx), .grant_valid(a_gv), .beat_count(a_cnt));
  logic_axi4_stream_mux_arbiter #(.INPUTS(3), .USE_TLAST(0), .MAX_BURST(4)) u_b (
    .aclk(aclk), .areset_n(areset_n), .request(b_req), .tlast(b_last), .tx_tready(b_rdy),
    .grant(b_grant), .grant_index(b_idx), .grant_valid(b_gv), .beat_count(b_cnt));
  logic_axi4_stream_mux_arbiter #(.INPUTS(2), .USE_TLAST(1), .MAX_BURST(2)) u_c (
    .aclk(aclk), .areset_n(areset_n), .request(c_req), .tlast(c_last), .tx_tready(c_rdy),
    .grant(c_grant), .grant_index(c_idx), .grant_valid(c_gv), .beat_count(c_cnt));

  typedef struct {
    int          dut;
    logic [2:0]  grant;
    logic [1:0]  idx;
    logic        gv;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per clock, compared just after the edge.
  logic [2:0]  m_g;
  logic [1:0]  m_i;
  logic        m_v;
  logic [15:0] m_c;
  always @(posedge aclk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      case (e.dut)
        0:       begin m_g = {1'b0, a_grant}; m_i = {1'b0, a_idx}; m_v = a_gv; m_c = a_cnt; end
        1:       begin m_g = b_grant;         m_i = b_idx;         m_v = b_gv; m_c = b_cnt; end
        default: begin m_g = {1'b0, c_grant}; m_i = {1'b0, c_idx}; m_v = c_gv; m_c = c_cnt; end
      endcase
      check({e.tag, ".grant"}, 32'(m_g), 32'(e.grant));
      check({e.tag, ".index"}, 32'(m_i), 32'(e.idx));
      check({e.tag, ".valid"}, 32'(m_v), 32'(e.gv));
      check({e.tag, ".count"}, 32'(m_c), 32'(e.cnt));
    end
  end

  // Drive one cycle of inputs to one DUT and queue the outputs expected after the edge.
  task automatic step(input int dut, input logic [2:0] req, input logic [2:0] last,
                      input logic rdy, input logic rn, input logic [2:0] g,
                      input logic [1:0] i, input logic [15:0] c, input string tag);
    exp_t e;
    @(negedge aclk);
    areset_n = rn;
    case (dut)
      0:       begin a_req = req[1:0]; a_last = last[1:0]; a_rdy = rdy; end
      1:       begin b_req = req;      b_last = last;      b_rdy = rdy; end
      default: begin c_req = req[1:0]; c_last = last[1:0]; c_rdy = rdy; end
    endcase
    e.dut = dut; e.grant = g; e.idx = i; e.gv = (g != 3'b000); e.cnt = c; e.tag = tag;
    sb.push_back(e);
    @(posedge aclk);
  endtask

  initial begin
    areset_n = 1'b0;
    a_req = '0; a_last = '0; a_rdy = 1'b1;
    b_req = '0; b_last = '0; b_rdy = 1'b1;
    c_req = '0; c_last = '0; c_rdy = 1'b1;
    repeat (2) @(posedge aclk);

    // reset state / idle with no requests
    step(0, 3'b000, 3'b000, 1, 1, 3'b000, 0, 0, "a_idle");
    step(1, 3'b000, 3'b000, 1, 1, 3'b000, 0, 0, "b_idle");
    step(2, 3'b000, 3'b000, 1, 1, 3'b000, 0, 0, "c_idle");

    // both request, 3-beat packets: input 0 first, no bubble on hand-over
    step(0, 3'b011, 3'b000, 1, 1, 3'b001, 0, 0, "a_first");
    step(0, 3'b011, 3'b000, 1, 1, 3'b001, 0, 1, "a_p0b1");
    step(0, 3'b011, 3'b000, 1, 1, 3'b001, 0, 2, "a_p0b2");
    step(0, 3'b011, 3'b001, 1, 1, 3'b010, 1, 0, "a_p0last");
    step(0, 3'b011, 3'b000, 1, 1, 3'b010, 1, 1, "a_p1b1");
    step(0, 3'b011, 3'b000, 1, 1, 3'b010, 1, 2, "a_p1b2");
    step(0, 3'b011, 3'b010, 1, 1, 3'b001, 0, 0, "a_p1last");
    // owner drops tvalid: held, no count; sole requester re-wins
    step(0, 3'b010, 3'b000, 1, 1, 3'b001, 0, 0, "a_ownerdrop");
    step(0, 3'b001, 3'b000, 1, 1, 3'b001, 0, 1, "a_solo_b1");
    step(0, 3'b001, 3'b001, 1, 1, 3'b001, 0, 0, "a_solo_regrant");
    step(0, 3'b000, 3'b000, 1, 1, 3'b001, 0, 0, "a_norq_hold");
    step(0, 3'b011, 3'b000, 1, 1, 3'b001, 0, 1, "a_q_b1");
    step(0, 3'b011, 3'b001, 1, 1, 3'b010, 1, 0, "a_q_last");
    // only input 1, back-to-back 2-beat packets
    step(0, 3'b010, 3'b000, 1, 1, 3'b010, 1, 1, "a_bb_b1");
    step(0, 3'b010, 3'b010, 1, 1, 3'b010, 1, 0, "a_bb_last1");
    step(0, 3'b010, 3'b000, 1, 1, 3'b010, 1, 1, "a_bb_b2");
    step(0, 3'b010, 3'b010, 1, 1, 3'b010, 1, 0, "a_bb_last2");
    // tready toggling through a 4-beat packet
    step(0, 3'b011, 3'b000, 1, 1, 3'b010, 1, 1, "a_tr_b1");
    step(0, 3'b011, 3'b000, 0, 1, 3'b010, 1, 1, "a_tr_stall1");
    step(0, 3'b011, 3'b000, 1, 1, 3'b010, 1, 2, "a_tr_b2");
    step(0, 3'b011, 3'b000, 0, 1, 3'b010, 1, 2, "a_tr_stall2");
    step(0, 3'b011, 3'b000, 1, 1, 3'b010, 1, 3, "a_tr_b3");
    step(0, 3'b011, 3'b010, 0, 1, 3'b010, 1, 3, "a_tr_laststall");
    step(0, 3'b011, 3'b010, 1, 1, 3'b001, 0, 0, "a_tr_last");
    // reset mid-packet while input 1 is granted
    step(0, 3'b011, 3'b001, 1, 1, 3'b010, 1, 0, "a_rs_grant1");
    step(0, 3'b011, 3'b000, 1, 1, 3'b010, 1, 1, "a_rs_b1");
    #2 areset_n = 1'b0;
    #1;
    check("a_async_rst.grant", 32'(a_grant), 32'd0);
    check("a_async_rst.valid", 32'(a_gv), 32'd0);
    check("a_async_rst.count", 32'(a_cnt), 32'd0);
    check("a_async_rst.index", 32'(a_idx), 32'd0);
    step(0, 3'b011, 3'b000, 1, 0, 3'b000, 0, 0, "a_in_rst");
    step(0, 3'b011, 3'b000, 1, 1, 3'b001, 0, 0, "a_after_rst");
    step(0, 3'b011, 3'b000, 1, 1, 3'b001, 0, 1, "a_after_rst_b1");

    // 3 inputs, all requesting, 4-beat bursts, tlast held high and ignored
    for (int n = 0; n < 13; n++) begin
      int gi;
      gi = (n / 4) % 3;
      step(1, 3'b111, 3'b111, 1, 1, 3'(1 << gi), 2'(gi), 16'(n % 4), $sformatf("b_rot%0d", n));
    end

    // burst limit 2 with tlast coinciding on beat 2, then limit alone cutting a long packet
    step(2, 3'b011, 3'b000, 1, 1, 3'b001, 0, 0, "c_first");
    step(2, 3'b011, 3'b000, 1, 1, 3'b001, 0, 1, "c_b1");
    step(2, 3'b011, 3'b001, 1, 1, 3'b010, 1, 0, "c_both_release");
    step(2, 3'b011, 3'b000, 1, 1, 3'b010, 1, 1, "c_p1b1");
    step(2, 3'b011, 3'b000, 1, 1, 3'b001, 0, 0, "c_burst_cut");
    step(2, 3'b011, 3'b000, 1, 1, 3'b001, 0, 1, "c_p0b1");

    @(negedge aclk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
